// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and the sample element type.
// The framer and its bank sub-module take their default sizes from here.
package fft_pkg;
   localparam int unsigned FFT_N  = 4;
   localparam int unsigned FFT_SW = 2;
   localparam int unsigned FFT_OW = 4;

   typedef logic [FFT_SW-1:0] fft_sample_t;
endpackage

// File: rtl/fft_frame_bank.sv
// One frame of N sample registers with an indexed write port and a full parallel read port.
// The framer instantiates this twice to form its ping-pong buffer.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int unsigned N  = FFT_N,
   parameter int unsigned SW = FFT_SW,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [IW-1:0] idx,
   input  logic [SW-1:0] wdata,
   output logic [SW-1:0] q [N-1:0]
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) q[i] <= '0;
      end else if (we) begin
         q[idx] <= wdata;
      end
   end

endmodule

// File: rtl/fft_sample_framer.sv
// Serial-to-parallel framer feeding fft_n4: packs N samples per frame into a two-bank buffer.
// Define FFT_FRAMER_SOF_ALIGN_EN to add the s_sof realignment input and the drop_cnt output.
module fft_sample_framer
   import fft_pkg::*;
#(
   parameter int unsigned N  = FFT_N,
   parameter int unsigned SW = FFT_SW,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [SW-1:0] s_data,
`ifdef FFT_FRAMER_SOF_ALIGN_EN
   input  logic          s_sof,
   output logic [CW-1:0] drop_cnt,
`endif
   output logic          f_valid,
   input  logic          f_ready,
   output logic [SW-1:0] f_x [N-1:0],
   output logic [CW-1:0] frame_cnt
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [1:0]    full_q;
   logic          wr_bank_q;
   logic          rd_bank_q;
   logic [IW-1:0] idx_q;
   logic [CW-1:0] frame_cnt_q;
   logic [IW-1:0] wr_idx;
   logic          accept;
   logic          handoff;
   logic          last;
   logic [SW-1:0] bank0_x [N-1:0];
   logic [SW-1:0] bank1_x [N-1:0];

   // s_ready depends only on registered state, so f_ready never reaches it combinationally.
   assign s_ready = !full_q[wr_bank_q];
   assign f_valid = full_q[rd_bank_q];
   assign accept  = s_valid && s_ready;
   assign handoff = f_valid && f_ready;

`ifdef FFT_FRAMER_SOF_ALIGN_EN
   logic [CW-1:0] drop_cnt_q;
   logic          restart;

   // A start-of-frame marker forces the write to slot 0, abandoning any partial frame.
   assign wr_idx   = (accept && s_sof) ? '0 : idx_q;
   assign restart  = accept && s_sof && (idx_q != '0);
   assign drop_cnt = drop_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else if (restart) begin
         drop_cnt_q <= drop_cnt_q + CW'(1);
      end
   end
`else
   assign wr_idx = idx_q;
`endif

   assign last = (wr_idx == IW'(N - 1));

   // Completion always targets the non-full write bank and handoff the full read bank,
   // so the two full_q updates below never touch the same bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q      <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         if (accept) begin
            if (last) begin
               full_q[wr_bank_q] <= 1'b1;
               wr_bank_q         <= !wr_bank_q;
               idx_q             <= '0;
            end else begin
               idx_q <= wr_idx + IW'(1);
            end
         end
         if (handoff) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= !rd_bank_q;
            frame_cnt_q       <= frame_cnt_q + CW'(1);
         end
      end
   end

   fft_frame_bank #(
      .N  (N),
      .SW (SW)
   ) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && !wr_bank_q),
      .idx   (wr_idx),
      .wdata (s_data),
      .q     (bank0_x)
   );

   fft_frame_bank #(
      .N  (N),
      .SW (SW)
   ) u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (accept && wr_bank_q),
      .idx   (wr_idx),
      .wdata (s_data),
      .q     (bank1_x)
   );

   always_comb begin
      for (int i = 0; i < N; i++) f_x[i] = rd_bank_q ? bank1_x[i] : bank0_x[i];
   end

   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_sample_framer.sv
// Directed bench for fft_sample_framer; inputs change and outputs are sampled 1ns after posedge.
// Define FFT_FRAMER_SOF_ALIGN_EN to also exercise start-of-frame realignment.
module tb_fft_sample_framer;
   import fft_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [1:0]  s_data = '0;
   logic        f_valid;
   logic        f_ready = 1'b0;
   logic [1:0]  f_x [3:0];
   logic [15:0] frame_cnt;
`ifdef FFT_FRAMER_SOF_ALIGN_EN
   logic        s_sof = 1'b0;
   logic [15:0] drop_cnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = !clk;

   fft_sample_framer #(
      .N  (4),
      .SW (2),
      .CW (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
`ifdef FFT_FRAMER_SOF_ALIGN_EN
      .s_sof     (s_sof),
      .drop_cnt  (drop_cnt),
`endif
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_x       (f_x),
      .frame_cnt (frame_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_frame(input string tag, input int e0, input int e1, input int e2,
                              input int e3);
      check({tag, "_x0"}, 32'(f_x[0]), 32'(e0));
      check({tag, "_x1"}, 32'(f_x[1]), 32'(e1));
      check({tag, "_x2"}, 32'(f_x[2]), 32'(e2));
      check({tag, "_x3"}, 32'(f_x[3]), 32'(e3));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      s_valid = 1'b0;
      f_ready = 1'b0;
`ifdef FFT_FRAMER_SOF_ALIGN_EN
      s_sof   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   // Offers one sample and waits (bounded) for it to be accepted.
   task automatic send(input logic [1:0] d);
      bit done = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int k = 0; k < 50 && !done; k++) begin
         done = s_ready;
         tick();
      end
      s_valid = 1'b0;
      if (!done) check("send_timeout", 32'd0, 32'd1);
   endtask

   // Reference 4-point DFT of the presented frame (real input).
   task automatic check_fft(input int er0, input int er1, input int er2, input int er3);
      int x0, x1, x2, x3;
      x0 = int'(f_x[0]); x1 = int'(f_x[1]); x2 = int'(f_x[2]); x3 = int'(f_x[3]);
      check("fft_xr0", 32'(x0 + x1 + x2 + x3), 32'(er0));
      check("fft_xr1", 32'(x0 - x2), 32'(er1));
      check("fft_xr2", 32'(x0 - x1 + x2 - x3), 32'(er2));
      check("fft_xr3", 32'(x0 - x2), 32'(er3));
      check("fft_xi1", 32'(x3 - x1), 32'd0);
      check("fft_xi3", 32'(x1 - x3), 32'd0);
   endtask

   initial begin
      logic [1:0] pat [8];
      int frames_seen;
      int ready_drops;
      bit stable;

      // 1: reset values
      do_reset();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_f_valid", 32'(f_valid), 32'd0);
      check_frame("rst", 0, 0, 0, 0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

      // f_ready with nothing presented has no effect
      f_ready = 1'b1;
      repeat (3) tick();
      f_ready = 1'b0;
      check("idle_ready_cnt", 32'(frame_cnt), 32'd0);
      check("idle_ready_s_ready", 32'(s_ready), 32'd1);

      // 2: single frame, held
      send(2'd2); send(2'd1); send(2'd0);
      check("single_not_yet", 32'(f_valid), 32'd0);
      send(2'd1);
      check("single_f_valid", 32'(f_valid), 32'd1);
      check_frame("single", 2, 1, 0, 1);
      check_fft(4, 2, 0, 2);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(f_valid && f_x[0] == 2'd2 && f_x[1] == 2'd1 && f_x[2] == 2'd0 && f_x[3] == 2'd1))
            stable = 1'b0;
      end
      check("single_stable", 32'(stable), 32'd1);
      check("single_s_ready", 32'(s_ready), 32'd1);

      // 3: backpressure fills both banks
      do_reset();
      pat = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
      s_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_data = pat[i];
         if (!s_ready) check("bp_ready_early", 32'(s_ready), 32'd1);
         tick();
      end
      s_data = 2'd2;
      check("bp_s_ready_9th", 32'(s_ready), 32'd0);
      repeat (3) tick();
      check("bp_stall_s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b0;
      check_frame("bp_first", 0, 1, 2, 3);
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      check("bp_s_ready_back", 32'(s_ready), 32'd1);
      check("bp_f_valid2", 32'(f_valid), 32'd1);
      check_frame("bp_second", 3, 2, 1, 0);
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      check("bp_frame_cnt", 32'(frame_cnt), 32'd2);
      check("bp_empty", 32'(f_valid), 32'd0);

      // 4: streaming at one sample per clock; sample i = (i + i/4) % 4
      do_reset();
      f_ready     = 1'b1;
      frames_seen = 0;
      ready_drops = 0;
      for (int c = 0; c < 410; c++) begin
         if (f_valid) begin
            for (int j = 0; j < 4; j++)
               check($sformatf("stream_f%0d_x%0d", frames_seen, j), 32'(f_x[j]),
                     32'((4 * frames_seen + j + frames_seen) % 4));
            frames_seen++;
         end
         if (c < 400) begin
            if (!s_ready) ready_drops++;
            s_valid = 1'b1;
            s_data  = 2'((c + c / 4) % 4);
         end else begin
            s_valid = 1'b0;
         end
         tick();
      end
      f_ready = 1'b0;
      check("stream_ready_drops", 32'(ready_drops), 32'd0);
      check("stream_frames_seen", 32'(frames_seen), 32'd100);
      check("stream_frame_cnt", 32'(frame_cnt), 32'd100);

      // 5: asynchronous reset with a held frame and a partial frame in flight
      send(2'd1); send(2'd1); send(2'd1); send(2'd1);
      send(2'd3); send(2'd3);
      check("mid_pre_f_valid", 32'(f_valid), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_f_valid", 32'(f_valid), 32'd0);
      check("mid_s_ready", 32'(s_ready), 32'd1);
      check_frame("mid", 0, 0, 0, 0);
      check("mid_frame_cnt", 32'(frame_cnt), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      send(2'd3); send(2'd2); send(2'd1); send(2'd0);
      check("mid_after_f_valid", 32'(f_valid), 32'd1);
      check_frame("mid_after", 3, 2, 1, 0);

`ifdef FFT_FRAMER_SOF_ALIGN_EN
      // 6: start-of-frame realignment drops a partial frame
      do_reset();
      send(2'd3); send(2'd3);
      s_sof = 1'b1;
      send(2'd1);
      s_sof = 1'b0;
      send(2'd2); send(2'd3);
      check("sof_not_yet", 32'(f_valid), 32'd0);
      send(2'd0);
      check("sof_f_valid", 32'(f_valid), 32'd1);
      check_frame("sof", 1, 2, 3, 0);
      check("sof_drop_cnt", 32'(drop_cnt), 32'd1);
      f_ready = 1'b1;
      tick();
      f_ready = 1'b0;
      check("sof_frame_cnt", 32'(frame_cnt), 32'd1);
      check("sof_single", 32'(f_valid), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
